// File: rtl/parity4_pkg.sv
// Shared definitions for the parity4 generator/receiver pair.
package parity4_pkg;

  localparam int unsigned DATA_BITS  = 4;
  localparam int unsigned FRAME_BITS = 7;  // start + data + parity + stop

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Parity bit a transmitter would send for this nibble.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] nibble, input logic even);
    return even ? (^nibble) : ~(^nibble);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser; resets to 1 so an idle-high line shows no edge.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/parity4_rx.sv
// Serial receiver for 4-bit parity-protected frames with sticky error LED.
module parity4_rx
  import parity4_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned EVEN_PARITY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       err_clr,
  output logic [3:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       led
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] FullLoad = TimerW'(CLKS_PER_BIT - 1);
  localparam logic EvenPar = (EVEN_PARITY != 0);

  logic din_s;
  logic din_prev_q;
  logic fall;
  logic tick;

  state_e state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [1:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;

  logic                 frame_done;
  logic                 perr_new;
  logic                 ferr_new;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 led_q;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  // Edge detect needs a high-to-low transition, so a line stuck low after a
  // framing error cannot re-arm until it has returned high.
  assign fall = din_prev_q & ~din_s;
  assign tick = (timer_q == '0);

  // State register, bit timer and deserialiser storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      pbit_q     <= 1'b0;
      din_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      pbit_q     <= pbit_d;
      din_prev_q <= din_s;
    end
  end

  // Next-state: timer reloads on every expiry, so it never wraps
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q : timer_q - 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pbit_d  = pbit_q;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          timer_d = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (!din_s) begin
            idx_d   = '0;
            timer_d = FullLoad;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shreg_d[idx_q] = din_s;
          timer_d        = FullLoad;
          if (idx_q == 2'(DATA_BITS - 1)) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          pbit_d  = din_s;
          timer_d = FullLoad;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame completion and error evaluation at the stop-bit sample
  always_comb begin
    frame_done = (state_q == StStop) && tick;
    perr_new   = calc_parity(shreg_q, EvenPar) ^ pbit_q;
    ferr_new   = ~din_s;
  end

  // Result registers and sticky LED; a setting event beats err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      valid_q <= frame_done;
      if (frame_done) begin
        data_q       <= shreg_q;
        parity_err_q <= perr_new;
        frame_err_q  <= ferr_new;
      end
      if (frame_done && (perr_new || ferr_new)) begin
        led_q <= 1'b1;
      end else if (err_clr) begin
        led_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign led        = led_q;

endmodule

// File: tb/tb_parity4_rx.sv
// Self-checking bench for parity4_rx: an even-parity and an odd-parity instance.
module tb_parity4_rx;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din0 = 1'b1, din1 = 1'b1;
  logic       err_clr0 = 1'b0, err_clr1 = 1'b0;
  logic [3:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, led0, led1;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  // Vectors are {data[3:0], parity_err, frame_err, led}
  logic [6:0]  exp0[$], exp1[$], obs0[$], obs1[$];
  int unsigned cyc1[$];

  parity4_rx #(.CLKS_PER_BIT(Cpb), .EVEN_PARITY(1)) dut_even (
    .clk(clk), .rst(rst), .din(din0), .err_clr(err_clr0), .data(data0), .valid(valid0),
    .parity_err(perr0), .frame_err(ferr0), .led(led0)
  );

  parity4_rx #(.CLKS_PER_BIT(Cpb), .EVEN_PARITY(0)) dut_odd (
    .clk(clk), .rst(rst), .din(din1), .err_clr(err_clr1), .data(data1), .valid(valid1),
    .parity_err(perr1), .frame_err(ferr1), .led(led1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every completed frame seen on the valid strobes
  always @(negedge clk) begin
    if (valid0) obs0.push_back({data0, perr0, ferr0, led0});
    if (valid1) begin
      obs1.push_back({data1, perr1, ferr1, led1});
      cyc1.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; caller is 1 time unit after a rising edge.
  task automatic send_frame(input bit sel, input logic [3:0] nib, input logic pbit,
                            input logic stop);
    logic [6:0] bits;
    bits = {stop, pbit, nib, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (sel) din1 = bits[i];
      else     din0 = bits[i];
      tick(Cpb);
    end
  endtask

  task automatic wait_obs(input bit sel, input int n, output bit ok);
    int k = 0;
    while (((sel ? obs1.size() : obs0.size()) < n) && (k < 400)) begin
      tick(1);
      k++;
    end
    ok = ((sel ? obs1.size() : obs0.size()) >= n);
  endtask

  task automatic test_reset;
    tick(4);
    @(negedge clk);
    checks++;
    if ({data0, valid0, perr0, ferr0, led0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_even: got %b want 00000000", {data0, valid0, perr0, ferr0, led0});
    end
    checks++;
    if ({data1, valid1, perr1, ferr1, led1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_odd: got %b want 00000000", {data1, valid1, perr1, ferr1, led1});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_good_frame;
    bit ok;
    logic [6:0] got, want;
    exp0.push_back({4'hB, 1'b0, 1'b0, 1'b0});
    send_frame(1'b0, 4'b1011, 1'b1, 1'b1);
    wait_obs(1'b0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL good_frame_valid: got no valid want 1 valid");
    end else begin
      got = obs0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL good_frame: got %b want %b", got, want);
      end
    end
    tick(20);
    checks++;
    if (obs0.size() != 0) begin
      errors++;
      $display("FAIL good_frame_single_pulse: got %0d extra want 0", obs0.size());
    end
    exp0.delete(); obs0.delete();
  endtask

  task automatic test_parity_error;
    bit ok;
    logic [6:0] got, want;
    exp0.push_back({4'h6, 1'b1, 1'b0, 1'b1});
    exp0.push_back({4'h9, 1'b0, 1'b0, 1'b1});  // clean frame, led stays set
    send_frame(1'b0, 4'b0110, 1'b1, 1'b1);
    send_frame(1'b0, 4'b1001, 1'b0, 1'b1);
    wait_obs(1'b0, 2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL parity_err_valid: got %0d valids want 2", obs0.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (obs0.size() > 0 && exp0.size() > 0) begin
        got = obs0.pop_front(); want = exp0.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL parity_err[%0d]: got %b want %b", i, got, want);
        end
      end
    end
    exp0.delete(); obs0.delete();
    tick(3);
    err_clr0 = 1'b1;
    @(negedge clk);
    checks++;
    if (led0 !== 1'b1) begin
      errors++;
      $display("FAIL led_before_clr: got %b want 1", led0);
    end
    @(posedge clk); #1;
    err_clr0 = 1'b0;
    @(negedge clk);
    checks++;
    if (led0 !== 1'b0) begin
      errors++;
      $display("FAIL led_after_clr: got %b want 0", led0);
    end
    tick(2);
  endtask

  task automatic test_frame_error;
    bit ok;
    logic [6:0] got, want;
    exp0.push_back({4'h3, 1'b0, 1'b1, 1'b1});
    send_frame(1'b0, 4'h3, 1'b0, 1'b0);
    wait_obs(1'b0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_err_valid: got no valid want 1 valid");
    end else begin
      got = obs0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_err: got %b want %b", got, want);
      end
    end
    exp0.delete(); obs0.delete();
    din0 = 1'b1;
    tick(2 * Cpb);
    checks++;
    if (obs0.size() != 0) begin
      errors++;
      $display("FAIL frame_err_rearm: got %0d valids want 0", obs0.size());
    end
    exp0.push_back({4'hA, 1'b0, 1'b0, 1'b1});
    send_frame(1'b0, 4'hA, 1'b0, 1'b1);
    wait_obs(1'b0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL after_frame_err_valid: got no valid want 1 valid");
    end else begin
      got = obs0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL after_frame_err: got %b want %b", got, want);
      end
    end
    exp0.delete(); obs0.delete();
  endtask

  task automatic test_false_start;
    din0 = 1'b0;
    tick(3);
    din0 = 1'b1;
    tick(10);
    checks++;
    if (dut_even.state_q !== parity4_pkg::StIdle) begin
      errors++;
      $display("FAIL false_start_idle: got state %0d want %0d", dut_even.state_q,
               parity4_pkg::StIdle);
    end
    tick(8 * Cpb);
    checks++;
    if (obs0.size() != 0) begin
      errors++;
      $display("FAIL false_start_novalid: got %0d valids want 0", obs0.size());
    end
    obs0.delete();
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    logic [6:0] got, want;
    // Upper bits of 4'hC, parity and stop are all high, so nothing after the
    // reset looks like a new start edge.
    fork
      send_frame(1'b0, 4'hC, 1'b1, 1'b1);
      begin
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({data0, valid0, perr0, ferr0, led0} !== 8'h00) begin
          errors++;
          $display("FAIL reset_mid_frame: got %b want 00000000",
                   {data0, valid0, perr0, ferr0, led0});
        end
      end
    join
    tick(Cpb);
    checks++;
    if (obs0.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_novalid: got %0d valids want 0", obs0.size());
    end
    obs0.delete();
    exp0.push_back({4'h5, 1'b0, 1'b0, 1'b0});
    send_frame(1'b0, 4'h5, 1'b0, 1'b1);
    wait_obs(1'b0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL after_reset_valid: got no valid want 1 valid");
    end else begin
      got = obs0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL after_reset: got %b want %b", got, want);
      end
    end
    exp0.delete(); obs0.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6:0] got, want;
    int unsigned c_prev, c_now;
    logic [3:0] nibs [3];
    nibs[0] = 4'h0; nibs[1] = 4'hF; nibs[2] = 4'h5;
    obs1.delete(); cyc1.delete();
    for (int i = 0; i < 3; i++) exp1.push_back({nibs[i], 1'b0, 1'b0, 1'b0});
    // All three nibbles have even weight, so the odd parity bit is 1
    for (int i = 0; i < 3; i++) send_frame(1'b1, nibs[i], 1'b1, 1'b1);
    wait_obs(1'b1, 3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_valid: got %0d valids want 3", obs1.size());
    end
    c_prev = 0;
    for (int i = 0; i < 3; i++) begin
      if (obs1.size() > 0 && exp1.size() > 0) begin
        got = obs1.pop_front(); want = exp1.pop_front(); c_now = cyc1.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b[%0d]: got %b want %b", i, got, want);
        end
        if (i > 0) begin
          checks++;
          if (c_now - c_prev != 7 * Cpb) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, c_now - c_prev, 7 * Cpb);
          end
        end
        c_prev = c_now;
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
